range_parser: RTL and testbench
===============================

# range_parser

Byte-serial ASCII front end for the fresh-ingredient checker. It consumes the puzzle input one character at a time and parses range lines into `{low, high, fresh}` records for the range FIFO write port. After the blank separator line it parses ingredient-ID lines into check addresses. It sits directly upstream of the fresh-ingredient block, in that block's `range_clk` domain.

## Interface
- `ADDR_W`, 17, width of every parsed number and output address
- `CNT_W`, 16, width of the record counters

- `clk`  in  1  parser clock; connected to the checker's `range_clk`
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_byte` is valid
- `in_byte`  in  8  ASCII character
- `in_last`  in  1  qualifies the final byte of the input
- `in_ready`  out  1  parser accepts `in_byte` this cycle
- `range_valid`  out  1  range record valid; drives FIFO `wr_en` through `range_ready` gating
- `range_low`  out  ADDR_W  inclusive range start
- `range_high`  out  ADDR_W  inclusive range end
- `range_fresh`  out  1  1 = fresh range, 0 = spoiled range (line prefixed `!`)
- `range_ready`  in  1  from checker `fifo_ready`
- `id_valid`  out  1  ingredient ID valid
- `id_addr`  out  ADDR_W  ingredient ID
- `id_ready`  in  1  ID consumer ready
- `range_count`  out  CNT_W  ranges emitted
- `id_count`  out  CNT_W  IDs emitted
- `done`  out  1  sticky; `in_last` was processed and all outputs drained
- `err`  out  1  sticky; malformed or overflowing line seen

## Operation
- States:
  - `S_LOW`: parse low / detect blank line
  - `S_HIGH`: parse high
  - `S_RANGE_OUT`: holding range record
  - `S_ID`: parse ID
  - `S_ID_OUT`: holding ID
  - `S_SKIP`: discard to `'\n'`
  - `S_DONE`
- Character classes:
  - digits `'0'`–`'9'`: `acc <= acc*10 + (byte-'0')`, computed at ADDR_W+4 bits.
  - Result > 2^ADDR_W−1 → set `err`, go to `S_SKIP`.
  - `'\r'` is ignored in every state.
- `S_LOW`:
  - `'!'` as the first character of the line → fresh_n flag.
  - `'-'` with ≥1 digit → latch low, clear acc, go to `S_HIGH`.
  - `'\n'` with no digits and no `'!'` → go to `S_ID` (separator).
  - Any other byte → `err`, go to `S_SKIP`.
- `S_HIGH`:
  - `'\n'` with ≥1 digit:
    - low ≤ high → load output regs, go to `S_RANGE_OUT`.
    - low > high → `err`, record dropped, go to `S_LOW`.
  - Any other byte → `err`, go to `S_SKIP`.
- `S_RANGE_OUT`: hold until `range_valid && range_ready`, then `range_count++` and go to `S_LOW`.
- `S_ID`:
  - `'\n'` with ≥1 digit → go to `S_ID_OUT`.
  - Empty line → ignored.
  - Any other byte → `err`, go to `S_SKIP`.
- `S_ID_OUT`: hold until the handshake completes, then `id_count++` and go to `S_ID`.
- `S_SKIP`: discard until `'\n'`, then return to the section state (`S_LOW` or `S_ID`); the line emits nothing.
- `in_last`:
  - If the final line is unterminated, it is treated as if `'\n'` followed it.
  - After the last record drains → `S_DONE`, `done` = 1, `in_ready` = 0 permanently.
- Counters saturate at all-ones.

## Timing
- Reset values:
  - `in_ready` = 0 during reset, 1 in the first cycle after reset
  - all valids = 0, all data = 0, counters = 0, `done` = 0, `err` = 0, state = `S_LOW`
- One byte per cycle when `in_ready`; `in_ready` = 0 in `S_RANGE_OUT`, `S_ID_OUT` and `S_DONE`. Inputs need no bypass.
- Latency: `range_valid`/`id_valid` rise the cycle after the terminating `'\n'` (or `in_last` byte) is accepted.
- Handshakes: once a valid is asserted, it and its data are held stable until ready. The transfer completes on the rising edge where both are high. Valid deasserts the next cycle, and `in_ready` returns the same cycle.
- Minimum record period: line length + 1 cycles.
- `rst_n` asserted mid-line or mid-handshake:
  - all state is cleared immediately; the partial record is lost
  - valids drop asynchronously

## Structure
- Shared package:
  - ASCII constants (`'0'`, `'9'`, `'-'`, `'!'`, `'\n'`, `'\r'`)
  - state enum
  - `ADDR_W` default
- One natural sub-module, `dec_accum`:
  - clear/shift-in-digit accumulator with overflow flag
  - instantiated once and shared by low/high/ID; high reuses it after low is latched

## Test plan
- Bytes `"3-5\n10-14\n\n5\n"` with `in_last` on the final byte → ranges (3,5,1), (10,14,1); ID 5; counts 2/1; `done`=1, `err`=0.
- `"!12-18\n"` → range (12,18,0).
- `range_ready` held 0 for 20 cycles during (3,5) → `range_valid` held, data stable, `in_ready`=0; one transfer when released.
- `"131072-5\n7-9\n"` at ADDR_W=17 → overflow: `err`=1, only (7,9,1) emitted.
- `"9-4\n"` → `err`=1, no record; `"1-2\r\n"` → (1,2,1).
- `rst_n` pulsed low while (3,5) pending → valid 0 at once; restart parses the next stream from `S_LOW`, counters 0.

Source files
------------

// File: rtl/range_parser_pkg.sv
// Shared definitions for the range_parser front end.
//   - ASCII character constants used by the line parser
//   - parser state enumeration
//   - default widths for parsed numbers and record counters
//   - is_digit(): ASCII digit classifier
package range_parser_pkg;

    localparam int ADDR_W_DEF = 17;
    localparam int CNT_W_DEF  = 16;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_BANG = 8'h21;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_CR   = 8'h0D;

    typedef enum logic [2:0] {
        S_LOW       = 3'd0,
        S_HIGH      = 3'd1,
        S_RANGE_OUT = 3'd2,
        S_ID        = 3'd3,
        S_ID_OUT    = 3'd4,
        S_SKIP      = 3'd5,
        S_DONE      = 3'd6
    } state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/range_parser_dec_accum.sv
// Decimal accumulator shared by the low, high and ID fields.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : clear value and digit flag (wins over shift_i)
//   shift_i      : acc <= acc*10 + digit_i
//   digit_i      : decimal digit value 0..9
//   acc_o        : current accumulated value
//   nxt_o        : value that a shift of digit_i would produce
//   ovf_o        : that shift would exceed W bits
//   has_digit_o  : at least one digit shifted in since the last clear
module dec_accum
    import range_parser_pkg::*;
#(
    parameter int W = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         shift_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] nxt_o,
    output logic         ovf_o,
    output logic         has_digit_o
);

    logic [W-1:0] acc_q;
    logic         has_q;
    logic [W+3:0] ext_s;

    // Four guard bits hold acc*10+9 for any W-bit acc, so overflow is exact.
    assign ext_s       = ({4'd0, acc_q} * (W+4)'(10)) + {{W{1'b0}}, digit_i};
    assign nxt_o       = ext_s[W-1:0];
    assign ovf_o       = |ext_s[W+3:W];
    assign acc_o       = acc_q;
    assign has_digit_o = has_q;

    // Accumulator register: clear has priority over digit shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            has_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= '0;
            has_q <= 1'b0;
        end else if (shift_i) begin
            acc_q <= ext_s[W-1:0];
            has_q <= 1'b1;
        end
    end

endmodule

// File: rtl/range_parser.sv
// Byte-serial ASCII parser: "[!]low-high" lines, a blank separator line,
// then ingredient-ID lines. Emits range records and IDs over valid/ready.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_byte/in_last      : input byte stream, in_ready back-pressure
//   range_valid/low/high/fresh    : range record, accepted with range_ready
//   id_valid/id_addr              : ingredient ID, accepted with id_ready
//   range_count/id_count          : saturating emitted-record counters
//   done/err                      : sticky end-of-input and malformed-line flags
module range_parser
    import range_parser_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              range_valid,
    output logic [ADDR_W-1:0] range_low,
    output logic [ADDR_W-1:0] range_high,
    output logic              range_fresh,
    input  logic              range_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_addr,
    input  logic              id_ready,
    output logic [CNT_W-1:0]  range_count,
    output logic [CNT_W-1:0]  id_count,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic              in_ready_q, sec_q, bang_q, last_q, done_q, err_q;
    logic [ADDR_W-1:0] low_q;
    logic              range_valid_q, range_fresh_q, id_valid_q;
    logic [ADDR_W-1:0] range_low_q, range_high_q, id_addr_q;
    logic [CNT_W-1:0]  range_count_q, id_count_q;

    logic              accept_s, parse_st_s, eol_s;
    logic              acc_clr_s, acc_shift_s, acc_ovf_s, acc_has_s;
    logic [ADDR_W-1:0] acc_val_s, acc_nxt_s, val_s;
    logic              has_s, bang_d, err_s, to_high_s, skip_s, sep_s;
    logic              emit_rng_s, emit_id_s;

    assign accept_s   = in_valid && in_ready_q;
    assign parse_st_s = (state_q == S_LOW) || (state_q == S_HIGH) || (state_q == S_ID);
    // An in_last byte closes its line exactly as a following '\n' would.
    assign eol_s      = accept_s && ((in_byte == CH_LF) || in_last);

    dec_accum #(.W(ADDR_W)) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (acc_clr_s),
        .shift_i    (acc_shift_s),
        .digit_i    (in_byte[3:0]),   // low nibble of '0'..'9' is the digit value
        .acc_o      (acc_val_s),
        .nxt_o      (acc_nxt_s),
        .ovf_o      (acc_ovf_s),
        .has_digit_o(acc_has_s)
    );

    // Byte decode: first the character itself, then the line terminator
    // (real '\n' or in_last) using the post-character value and digit flag.
    always_comb begin
        state_d     = state_q;
        acc_clr_s   = 1'b0;
        acc_shift_s = 1'b0;
        err_s       = 1'b0;
        bang_d      = bang_q;
        to_high_s   = 1'b0;
        skip_s      = 1'b0;
        sep_s       = 1'b0;
        emit_rng_s  = 1'b0;
        emit_id_s   = 1'b0;
        has_s       = acc_has_s;
        val_s       = acc_val_s;
        if (accept_s) begin
            if (is_digit(in_byte)) begin
                if (parse_st_s && acc_ovf_s) begin
                    err_s  = 1'b1;
                    skip_s = 1'b1;
                end else if (parse_st_s) begin
                    acc_shift_s = 1'b1;
                    has_s       = 1'b1;
                    val_s       = acc_nxt_s;
                end else begin
                    skip_s = 1'b0;
                end
            end else if ((in_byte == CH_LF) || (in_byte == CH_CR)) begin
                skip_s = 1'b0;
            end else if ((state_q == S_LOW) && (in_byte == CH_BANG) && !acc_has_s && !bang_q) begin
                bang_d = 1'b1;
            end else if ((state_q == S_LOW) && (in_byte == CH_DASH) && acc_has_s) begin
                to_high_s = 1'b1;
                acc_clr_s = 1'b1;
            end else if (state_q != S_SKIP) begin
                err_s  = 1'b1;
                skip_s = 1'b1;
            end else begin
                skip_s = 1'b0;
            end

            if (eol_s) begin
                acc_clr_s = 1'b1;
                if (skip_s || (state_q == S_SKIP)) begin
                    state_d = sec_q ? S_ID : S_LOW;
                end else begin
                    case (state_q)
                        S_LOW: begin
                            if (!to_high_s && !has_s && !bang_d) begin
                                sep_s   = 1'b1;
                                state_d = S_ID;
                            end else begin
                                err_s   = 1'b1;
                                state_d = S_LOW;
                            end
                        end
                        S_HIGH: begin
                            if (has_s && (low_q <= val_s)) begin
                                emit_rng_s = 1'b1;
                                state_d    = S_RANGE_OUT;
                            end else begin
                                err_s   = 1'b1;
                                state_d = S_LOW;
                            end
                        end
                        S_ID: begin
                            if (has_s) begin
                                emit_id_s = 1'b1;
                                state_d   = S_ID_OUT;
                            end else begin
                                state_d = S_ID;
                            end
                        end
                        default: state_d = S_LOW;
                    endcase
                end
                bang_d = 1'b0;
                // Nothing left to drain: finish immediately.
                if (in_last && !emit_rng_s && !emit_id_s) begin
                    state_d = S_DONE;
                end else begin
                    bang_d = 1'b0;
                end
            end else if (skip_s) begin
                state_d = S_SKIP;
            end else if (to_high_s) begin
                state_d = S_HIGH;
            end else begin
                state_d = state_q;
            end
        end else begin
            case (state_q)
                S_RANGE_OUT: begin
                    if (range_valid_q && range_ready) begin
                        state_d = last_q ? S_DONE : S_LOW;
                    end else begin
                        state_d = S_RANGE_OUT;
                    end
                end
                S_ID_OUT: begin
                    if (id_valid_q && id_ready) begin
                        state_d = last_q ? S_DONE : S_ID;
                    end else begin
                        state_d = S_ID_OUT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Parser state, output records, handshakes and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_LOW;
            in_ready_q    <= 1'b0;
            sec_q         <= 1'b0;
            bang_q        <= 1'b0;
            last_q        <= 1'b0;
            low_q         <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            range_valid_q <= 1'b0;
            range_low_q   <= '0;
            range_high_q  <= '0;
            range_fresh_q <= 1'b0;
            id_valid_q    <= 1'b0;
            id_addr_q     <= '0;
            range_count_q <= '0;
            id_count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == S_LOW) || (state_d == S_HIGH) ||
                          (state_d == S_ID)  || (state_d == S_SKIP);
            if (state_d == S_DONE) done_q <= 1'b1;
            if (err_s)             err_q  <= 1'b1;
            if (sep_s)             sec_q  <= 1'b1;
            if (to_high_s)         low_q  <= acc_val_s;
            if (accept_s) begin
                bang_q <= bang_d;
                last_q <= in_last;
            end
            if (emit_rng_s) begin
                range_valid_q <= 1'b1;
                range_low_q   <= low_q;
                range_high_q  <= val_s;
                range_fresh_q <= ~bang_q;
            end else if (range_valid_q && range_ready) begin
                range_valid_q <= 1'b0;
                if (range_count_q != {CNT_W{1'b1}}) range_count_q <= range_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (emit_id_s) begin
                id_valid_q <= 1'b1;
                id_addr_q  <= val_s;
            end else if (id_valid_q && id_ready) begin
                id_valid_q <= 1'b0;
                if (id_count_q != {CNT_W{1'b1}}) id_count_q <= id_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign range_valid = range_valid_q;
    assign range_low   = range_low_q;
    assign range_high  = range_high_q;
    assign range_fresh = range_fresh_q;
    assign id_valid    = id_valid_q;
    assign id_addr     = id_addr_q;
    assign range_count = range_count_q;
    assign id_count    = id_count_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_range_parser.sv
module tb_range_parser;
    localparam int     ADDR_W = 17;
    localparam int     CNT_W  = 16;
    localparam longint MAXV   = 131071;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              in_valid = 1'b0, in_last = 1'b0;
    logic [7:0]        in_byte = 8'd0;
    logic              range_ready = 1'b0, id_ready = 1'b0;
    logic              in_ready, range_valid, range_fresh, id_valid, done, err;
    logic [ADDR_W-1:0] range_low, range_high, id_addr;
    logic [CNT_W-1:0]  range_count, id_count;

    range_parser #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
        .in_ready(in_ready), .range_valid(range_valid), .range_low(range_low),
        .range_high(range_high), .range_fresh(range_fresh), .range_ready(range_ready),
        .id_valid(id_valid), .id_addr(id_addr), .id_ready(id_ready),
        .range_count(range_count), .id_count(id_count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { longint lo; longint hi; bit fresh; } rng_t;
    rng_t         exp_rng[$];
    longint       exp_id[$];
    byte unsigned stream[$];
    int           n_cmp = 0, n_bad = 0;
    bit           exp_err;
    int           exp_nr, exp_ni;
    bit           hold_rng = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: whole-line parsing ----------------
    function automatic void parse_digits(input byte unsigned ln[$], inout int p,
                                         output int nd, output longint v);
        nd = 0; v = 0;
        while (p < ln.size() && ln[p] >= 8'h30 && ln[p] <= 8'h39) begin
            if (v <= 64'd10000000) v = v * 10 + (longint'(ln[p]) - 48);
            nd++; p++;
        end
    endfunction

    function automatic void model_line(input byte unsigned ln[$], inout int sec);
        int p, n1, n2; longint lo, hi; bit fr;
        p = 0; n2 = 0; hi = 0;
        if (sec == 0) begin
            if (ln.size() == 0) begin sec = 1; return; end
            fr = 1'b1;
            if (ln[0] == 8'h21) begin fr = 1'b0; p = 1; end
            parse_digits(ln, p, n1, lo);
            if (n1 > 0 && p < ln.size() && ln[p] == 8'h2D) begin
                p++;
                parse_digits(ln, p, n2, hi);
                if (n2 > 0 && p == ln.size() && lo <= MAXV && hi <= MAXV && lo <= hi) begin
                    exp_rng.push_back('{lo, hi, fr}); exp_nr++;
                    return;
                end
            end
            exp_err = 1'b1;
        end else begin
            if (ln.size() == 0) return;
            parse_digits(ln, p, n1, lo);
            if (n1 > 0 && p == ln.size() && lo <= MAXV) begin
                exp_id.push_back(lo); exp_ni++;
            end else exp_err = 1'b1;
        end
    endfunction

    function automatic void model_stream(input bit with_last);
        byte unsigned ln[$]; int sec;
        sec = 0;
        for (int i = 0; i < stream.size(); i++) begin
            if (stream[i] == 8'h0A) begin model_line(ln, sec); ln.delete(); end
            else if (stream[i] != 8'h0D) ln.push_back(stream[i]);
        end
        if (with_last && stream.size() > 0 && stream[stream.size()-1] != 8'h0A) model_line(ln, sec);
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic void push_str(input string s);
        for (int i = 0; i < s.len(); i++) stream.push_back(s[i]);
    endfunction

    function automatic void load(input string s);
        stream.delete();
        push_str(s);
    endfunction

    function automatic longint rand_val();
        case ($urandom_range(0, 9))
            0: return 131072 + $urandom_range(0, 100);
            1: return MAXV;
            2: return 0;
            default: return $urandom_range(0, 2000);
        endcase
    endfunction

    function automatic void gen_random();
        int nr, ni, k; longint a, b, t;
        stream.delete();
        nr = $urandom_range(1, 6);
        for (int r = 0; r < nr; r++) begin
            k = $urandom_range(0, 19);
            a = rand_val(); b = rand_val();
            if (k < 14 && a > b) begin t = a; a = b; b = t; end
            if ($urandom_range(0, 4) == 0) push_str("!");
            push_str($sformatf("%0d", a));
            if (k == 14) push_str("x"); else if (k == 15) push_str("--"); else push_str("-");
            push_str($sformatf("%0d", b));
            if ($urandom_range(0, 3) == 0) push_str("\015");
            push_str("\n");
        end
        if ($urandom_range(0, 3) != 0) begin
            push_str("\n");
            ni = $urandom_range(0, 6);
            for (int j = 0; j < ni; j++) begin
                k = $urandom_range(0, 9);
                if (k == 0) push_str("\n");
                else begin
                    if (k == 1) push_str("1a"); else push_str($sformatf("%0d", rand_val()));
                    push_str("\n");
                end
            end
        end
        if ($urandom_range(0, 1) == 0 && stream[stream.size()-1] == 8'h0A) void'(stream.pop_back());
    endfunction

    task automatic apply_reset(input bit chk);
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'd0;
        exp_rng.delete(); exp_id.delete();
        exp_err = 1'b0; exp_nr = 0; exp_ni = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (chk) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_range_valid", range_valid, 0);
            check("rst_id_valid", id_valid, 0);
            check("rst_range_low", range_low, 0);
            check("rst_id_addr", id_addr, 0);
            check("rst_counts", range_count + id_count, 0);
            check("rst_done_err", {done, err}, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (chk) check("in_ready_after_reset", in_ready, 1);
    endtask

    task automatic send_stream(input bit with_last);
        int budget;
        for (int i = 0; i < stream.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1; in_byte = stream[i];
            in_last  = with_last && (i == stream.size() - 1);
            budget = 0;
            forever begin
                @(negedge clk);
                if (in_ready || budget > 500) break;
                budget++;
            end
            if (!in_ready) begin
                n_cmp++; n_bad++;
                $display("FAIL in_ready_timeout: got 0, want 1 within 500 cycles");
                in_valid = 1'b0; in_last = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done_and_check(input string tag);
        int c;
        c = 0;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        @(negedge clk);
        check({tag, ".done"}, done, 1);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".range_count"}, range_count, exp_nr);
        check({tag, ".id_count"}, id_count, exp_ni);
        check({tag, ".ranges_left"}, exp_rng.size(), 0);
        check({tag, ".ids_left"}, exp_id.size(), 0);
        check({tag, ".in_ready"}, in_ready, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_directed(input string s, input string tag);
        apply_reset(1'b0);
        load(s); model_stream(1'b1);
        send_stream(1'b1);
        wait_done_and_check(tag);
    endtask

    task automatic hold_test();
        int c;
        apply_reset(1'b0);
        load("3-5\n7-9\n"); model_stream(1'b1);
        hold_rng = 1'b1;
        fork
            send_stream(1'b1);
            begin
                c = 0;
                while (!range_valid && c < 200) begin @(negedge clk); c++; end
                check("hold_seen", range_valid, 1);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    check("hold_valid", range_valid, 1);
                    check("hold_low", range_low, 3);
                    check("hold_high", range_high, 5);
                    check("hold_in_ready", in_ready, 0);
                end
                hold_rng = 1'b0;
            end
        join
        wait_done_and_check("hold");
    endtask

    task automatic reset_mid_test();
        apply_reset(1'b0);
        load("3-5\n");
        hold_rng = 1'b1;
        send_stream(1'b0);
        @(negedge clk);
        check("pend_valid", range_valid, 1);
        check("pend_low", range_low, 3);
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid_async", range_valid, 0);
        check("rst_in_ready_async", in_ready, 0);
        check("rst_count_async", range_count, 0);
        hold_rng = 1'b0;
        apply_reset(1'b0);
        load("7-9\n"); model_stream(1'b1);
        send_stream(1'b1);
        wait_done_and_check("restart");
    endtask

    // Consumer ready patterns, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            range_ready = hold_rng ? 1'b0 : ($urandom_range(0, 3) != 0);
            id_ready    = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every completed transfer and checks hold stability.
    logic              pv = 1'b0, pr = 1'b0, pf = 1'b0, iv = 1'b0, ir = 1'b0;
    logic [ADDR_W-1:0] pl = '0, ph = '0, pa = '0;
    rng_t              er;
    longint            ei;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0; iv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("range_held", range_valid, 1);
                    check("range_stable", {range_fresh, range_low, range_high}, {pf, pl, ph});
                end
                if (iv && !ir) begin
                    check("id_held", id_valid, 1);
                    check("id_stable", id_addr, pa);
                end
                if (range_valid && range_ready) begin
                    if (exp_rng.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL range_extra: got (%0d,%0d,%0d), want none", range_low, range_high, range_fresh);
                    end else begin
                        er = exp_rng.pop_front();
                        check("range_low", range_low, er.lo);
                        check("range_high", range_high, er.hi);
                        check("range_fresh", range_fresh, er.fresh);
                    end
                end
                if (id_valid && id_ready) begin
                    if (exp_id.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL id_extra: got %0d, want none", id_addr);
                    end else begin
                        ei = exp_id.pop_front();
                        check("id_addr", id_addr, ei);
                    end
                end
                pv = range_valid; pr = range_ready; pl = range_low; ph = range_high; pf = range_fresh;
                iv = id_valid; ir = id_ready; pa = id_addr;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset(1'b1);
        load("3-5\n10-14\n\n5\n"); model_stream(1'b1);
        send_stream(1'b1);
        wait_done_and_check("basic");
        run_directed("!12-18\n", "spoiled");
        hold_test();
        run_directed("131072-5\n7-9\n", "overflow");
        run_directed("9-4\n1-2\015\n", "order_cr");
        run_directed("4-6\n\n77", "unterminated");
        run_directed("0-131071\n\n\n131071\n131072\n", "bounds");
        reset_mid_test();
        for (int n = 0; n < 40; n++) begin
            apply_reset(1'b0);
            gen_random();
            model_stream(1'b1);
            send_stream(1'b1);
            wait_done_and_check($sformatf("rand%0d", n));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
